ring_johnson_counter: RTL

//   Parametrised shift-register counter: WIDTH-bit ring (one-hot) or Johnson (twisted-ring) mode,

---
 rtl/ring_ctr_pkg.sv | 29 ++
 rtl/ring_state_check.sv | 34 +++
 rtl/ring_johnson_counter.sv | 129 ++++++++++++
 3 files changed

// File: rtl/ring_ctr_pkg.sv
// ---------------------------------------------------------------------------
// ring_ctr_pkg
//   Shared types and helpers for the ring/Johnson shift-register counter.
//   - rc_mode_e : counter mode (ring = one-hot, Johnson = twisted ring)
//   - rc_dir_e  : shift direction (toward MSB / toward LSB)
//   - seed_val  : seed value for a mode, returned in a RC_MAX_W-bit vector.
//                 Callers cast it down to their own width.
// ---------------------------------------------------------------------------
package ring_ctr_pkg;

   typedef enum logic {RC_RING = 1'b0, RC_JOHNSON = 1'b1} rc_mode_e;
   typedef enum logic {RC_UP   = 1'b0, RC_DOWN    = 1'b1} rc_dir_e;

   // Widest counter the seed helper can describe.
   localparam int RC_MAX_W = 64;

   // Ring seed is one-hot at seed_idx; Johnson seed is all zeros.
   function automatic logic [RC_MAX_W-1:0] seed_val(input rc_mode_e mode,
                                                     input int       width,
                                                     input int       seed_idx);
      logic [RC_MAX_W-1:0] v;
      v = '0;
      if (mode == RC_RING && seed_idx >= 0 && seed_idx < width) begin
         v = {{(RC_MAX_W-1){1'b0}}, 1'b1} << seed_idx;
      end
      return v;
   endfunction

endpackage

// File: rtl/ring_state_check.sv
// ---------------------------------------------------------------------------
// ring_state_check
//   Combinational legality check of a counter pattern for a given mode.
//   Ports:
//     value  in  WIDTH  pattern to check
//     mode   in  1      0 = ring, 1 = Johnson
//     legal  out 1      ring: exactly one bit set
//                       Johnson: 0*1* or 1*0* (at most one adjacent-bit change)
// ---------------------------------------------------------------------------
module ring_state_check
   import ring_ctr_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0] value,
   input  logic             mode,
   output logic             legal
);

   // One bit per adjacent pair that differs; a Johnson pattern has at most one.
   logic [WIDTH-2:0] edges;

   assign edges = value[WIDTH-1:1] ^ value[WIDTH-2:0];

   always_comb begin
      legal = 1'b0;
      if (rc_mode_e'(mode) == RC_RING) begin
         legal = $onehot(value);
      end else begin
         legal = $onehot0(edges);
      end
   end

endmodule

// File: rtl/ring_johnson_counter.sv
// ---------------------------------------------------------------------------
// ring_johnson_counter
//   WIDTH-bit ring (one-hot) or Johnson (twisted ring) counter, bidirectional,
//   with enable, parallel load and a registered wrap pulse.
//   Optional feature macro: RING_SELF_CORRECT_EN
//     defined   : illegal loads and illegal held states are replaced by the
//                 seed and flagged with a one-cycle 'illegal' pulse.
//     undefined : load_val is loaded verbatim, 'illegal' stays 0.
//   Ports:
//     clk       in   1      rising-edge clock
//     reset     in   1      synchronous, active-high reset
//     en        in   1      advance one step on this edge
//     mode      in   1      0 = ring (period WIDTH), 1 = Johnson (period 2*WIDTH)
//     dir       in   1      0 = shift toward MSB, 1 = shift toward LSB
//     load      in   1      parallel load of load_val
//     load_val  in   WIDTH  value to load
//     q         out  WIDTH  counter state (registered)
//     wrap      out  1      one-cycle pulse: an advance returned q to the seed
//     illegal   out  1      one-cycle pulse: an illegal state was rejected
//   Edge priority: reset > mode change > (illegal q) > load > en > hold.
// ---------------------------------------------------------------------------
module ring_johnson_counter
   import ring_ctr_pkg::*;
#(
   parameter int WIDTH    = 4,
   parameter int SEED_IDX = 0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             mode,
   input  logic             dir,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] q,
   output logic             wrap,
   output logic             illegal
);

   logic [WIDTH-1:0] q_q, q_d;
   logic             wrap_q, wrap_d;
   logic             illegal_q, illegal_d;
   logic             mode_q;

   rc_mode_e         mode_e;
   rc_dir_e          dir_e;
   logic [WIDTH-1:0] seed;
   logic [WIDTH-1:0] adv;

   assign mode_e = rc_mode_e'(mode);
   assign dir_e  = rc_dir_e'(dir);

   // Seed always follows the incoming mode so a mode change reseeds directly.
   assign seed = WIDTH'(seed_val(mode_e, WIDTH, SEED_IDX));

   // One-step advance; Johnson inverts the bit that wraps around.
   always_comb begin
      adv = q_q;
      if (dir_e == RC_UP) begin
         adv = {q_q[WIDTH-2:0], (mode_e == RC_JOHNSON) ? ~q_q[WIDTH-1] : q_q[WIDTH-1]};
      end else begin
         adv = {(mode_e == RC_JOHNSON) ? ~q_q[0] : q_q[0], q_q[WIDTH-1:1]};
      end
   end

`ifdef RING_SELF_CORRECT_EN
   logic load_legal;
   logic q_legal;

   // load_val is judged against the incoming mode; q against the mode it was built in.
   ring_state_check #(.WIDTH(WIDTH)) u_chk_load (
      .value (load_val),
      .mode  (mode),
      .legal (load_legal)
   );

   ring_state_check #(.WIDTH(WIDTH)) u_chk_q (
      .value (q_q),
      .mode  (mode_q),
      .legal (q_legal)
   );
`endif

   always_comb begin
      q_d       = q_q;
      wrap_d    = 1'b0;
      illegal_d = 1'b0;
      if (mode != mode_q) begin
         q_d = seed;
`ifdef RING_SELF_CORRECT_EN
      end else if (!q_legal) begin
         q_d       = seed;
         illegal_d = 1'b1;
      end else if (load) begin
         if (load_legal) begin
            q_d = load_val;
         end else begin
            q_d       = seed;
            illegal_d = 1'b1;
         end
`else
      end else if (load) begin
         q_d = load_val;
`endif
      end else if (en) begin
         q_d    = adv;
         wrap_d = (adv == seed);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         q_q       <= seed;
         wrap_q    <= 1'b0;
         illegal_q <= 1'b0;
         mode_q    <= mode;
      end else begin
         q_q       <= q_d;
         wrap_q    <= wrap_d;
         illegal_q <= illegal_d;
         mode_q    <= mode;
      end
   end

   assign q       = q_q;
   assign wrap    = wrap_q;
   assign illegal = illegal_q;

endmodule
